// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light controller.
package tlc_pkg;

  localparam logic [1:0] LT_RED = 2'b00;
  localparam logic [1:0] LT_YEL = 2'b01;
  localparam logic [1:0] LT_GRN = 2'b10;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    SIDE_G = 3'd2,
    SIDE_Y = 3'd3,
    PED    = 3'd4
  } phase_e;

  // Hour bounds in BCD; BCD ordering matches numeric ordering so plain compares work.
  localparam logic [7:0] PEAK_AM_FIRST = 8'h07;
  localparam logic [7:0] PEAK_AM_LAST  = 8'h09;
  localparam logic [7:0] PEAK_PM_FIRST = 8'h17;
  localparam logic [7:0] PEAK_PM_LAST  = 8'h19;
  localparam logic [7:0] PM_FIRST      = 8'h12;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/tlc_clock.sv
// One-second prescaler and BCD hh:mm:ss time-of-day counter with pm/peak flags.
module tlc_clock
  import tlc_pkg::*;
#(
  parameter int CLKS_PER_SEC = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ena_i,
  output logic       tick_o,
  output logic [7:0] hh_o,
  output logic [7:0] mm_o,
  output logic [7:0] ss_o,
  output logic       pm_o,
  output logic       peak_o
);

  logic [31:0] presc_q, presc_d;
  logic [7:0]  hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;

  assign tick_o = ena_i && (presc_q == 32'(CLKS_PER_SEC - 1));

  always_comb begin
    presc_d = presc_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    if (ena_i) presc_d = tick_o ? '0 : presc_q + 32'd1;
    if (tick_o) begin
      ss_d = (ss_q == 8'h59) ? 8'h00 : bcd_inc(ss_q);
      if (ss_q == 8'h59) begin
        mm_d = (mm_q == 8'h59) ? 8'h00 : bcd_inc(mm_q);
        if (mm_q == 8'h59) hh_d = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
      hh_q    <= 8'h00;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
    end else begin
      presc_q <= presc_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
    end
  end

  assign hh_o   = hh_q;
  assign mm_o   = mm_q;
  assign ss_o   = ss_q;
  assign pm_o   = (hh_q >= PM_FIRST);
  assign peak_o = ((hh_q >= PEAK_AM_FIRST) && (hh_q <= PEAK_AM_LAST)) ||
                  ((hh_q >= PEAK_PM_FIRST) && (hh_q <= PEAK_PM_LAST));

endmodule

// File: rtl/tlc_top.sv
// Traffic-light controller: request latches, Moore phase FSM, phase timer and light decode.
// state  | meaning
// MAIN_G | main road green, waits for minimum and a side request
// MAIN_Y | main road yellow
// SIDE_G | requested side roads green (set frozen on entry)
// SIDE_Y | served side roads yellow
// PED    | pedestrian crossings green (off-peak only)
module tlc_top
  import tlc_pkg::*;
#(
  parameter int CLKS_PER_SEC = 1,
  parameter int T_MAIN_PEAK  = 40,
  parameter int T_MAIN_OFF   = 20,
  parameter int T_SIDE_PEAK  = 10,
  parameter int T_SIDE_OFF   = 15,
  parameter int T_YEL        = 3,
  parameter int T_PED        = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       sensor1,
  input  logic       sensor2,
  output logic [1:0] TL1,
  output logic [1:0] TL2,
  output logic [1:0] TL3,
  output logic [1:0] TL4,
  output logic [1:0] TL5,
  output logic [1:0] TL6,
  output logic       peak,
  output logic       pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss
);

  phase_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] req_q, req_d, srv_q, srv_d;
  logic       tick, done;
  logic [7:0] main_len, side_len;

  tlc_clock #(.CLKS_PER_SEC(CLKS_PER_SEC)) u_clock (
    .clk_i  (clk),
    .rst_i  (reset),
    .ena_i  (ena),
    .tick_o (tick),
    .hh_o   (hh),
    .mm_o   (mm),
    .ss_o   (ss),
    .pm_o   (pm),
    .peak_o (peak)
  );

  assign main_len = peak ? 8'(T_MAIN_PEAK) : 8'(T_MAIN_OFF);
  assign side_len = peak ? 8'(T_SIDE_PEAK) : 8'(T_SIDE_OFF);
  // Timer holds ticks remaining including the current one; a value of 1 means this tick ends the phase.
  assign done     = (timer_q <= 8'd1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    srv_d   = srv_q;
    req_d   = req_q | {sensor2, sensor1};
    if (tick) begin
      if (!done) timer_d = timer_q - 8'd1;
      case (state_q)
        MAIN_G: if (done && (req_q != 2'b00)) begin
          state_d = MAIN_Y;
          timer_d = 8'(T_YEL);
        end
        MAIN_Y: if (done) begin
          state_d = SIDE_G;
          timer_d = side_len;
          srv_d   = req_q;
        end
        SIDE_G: if (done) begin
          state_d = SIDE_Y;
          timer_d = 8'(T_YEL);
        end
        SIDE_Y: if (done) begin
          req_d   = 2'b00;
          state_d = peak ? MAIN_G : PED;
          timer_d = peak ? main_len : 8'(T_PED);
        end
        PED: if (done) begin
          state_d = MAIN_G;
          timer_d = main_len;
        end
        default: begin
          state_d = MAIN_G;
          timer_d = main_len;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MAIN_G;
      timer_q <= 8'(T_MAIN_OFF);
      req_q   <= 2'b00;
      srv_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      srv_q   <= srv_d;
    end
  end

  always_comb begin
    TL1 = LT_RED;
    TL3 = LT_RED;
    TL4 = LT_RED;
    TL5 = LT_RED;
    case (state_q)
      MAIN_G: TL1 = LT_GRN;
      MAIN_Y: TL1 = LT_YEL;
      SIDE_G: begin
        TL3 = srv_q[0] ? LT_GRN : LT_RED;
        TL4 = srv_q[1] ? LT_GRN : LT_RED;
      end
      SIDE_Y: begin
        TL3 = srv_q[0] ? LT_YEL : LT_RED;
        TL4 = srv_q[1] ? LT_YEL : LT_RED;
      end
      PED:     TL5 = LT_GRN;
      default: TL1 = LT_RED;
    endcase
    TL2 = TL1;
    TL6 = TL5;
  end

endmodule

// File: tb/tb_tlc_top.sv
// Self-checking bench for tlc_top: directed phases plus random sensors against a tick-level model.
module tb_tlc_top;

  localparam int P_MG = 0, P_MY = 1, P_SG = 2, P_SY = 3, P_PED = 4;
  localparam logic [1:0] G = 2'b10, Y = 2'b01;

  logic       clk, reset, ena, sensor1, sensor2;
  logic [1:0] TL1, TL2, TL3, TL4, TL5, TL6;
  logic       peak, pm;
  logic [7:0] hh, mm, ss;

  int n_cmp = 0;
  int n_err = 0;

  // model: phase, ticks spent in phase, phase duration, request/served sets, seconds of day
  int       m_ph, m_len, m_dur, tsec;
  logic [1:0] m_rq, m_srv;

  tlc_top dut (
    .clk(clk), .reset(reset), .ena(ena), .sensor1(sensor1), .sensor2(sensor2),
    .TL1(TL1), .TL2(TL2), .TL3(TL3), .TL4(TL4), .TL5(TL5), .TL6(TL6),
    .peak(peak), .pm(pm), .hh(hh), .mm(mm), .ss(ss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_peak(input int s);
    int h = s / 3600;
    return ((h >= 7) && (h <= 9)) || ((h >= 17) && (h <= 19));
  endfunction

  function automatic logic [7:0] bcd(input int x);
    return 8'((x / 10) * 16 + (x % 10));
  endfunction

  function automatic logic [23:0] exp_time();
    return {bcd(tsec / 3600), bcd((tsec / 60) % 60), bcd(tsec % 60)};
  endfunction

  function automatic logic [1:0] exp_flags();
    return {is_peak(tsec), (tsec / 3600) >= 12};
  endfunction

  function automatic logic [11:0] exp_lights();
    logic [1:0] t1 = 2'b00, t3 = 2'b00, t4 = 2'b00, t5 = 2'b00;
    case (m_ph)
      P_MG: t1 = G;
      P_MY: t1 = Y;
      P_SG: begin t3 = m_srv[0] ? G : 2'b00; t4 = m_srv[1] ? G : 2'b00; end
      P_SY: begin t3 = m_srv[0] ? Y : 2'b00; t4 = m_srv[1] ? Y : 2'b00; end
      default: t5 = G;
    endcase
    return {t1, t1, t3, t4, t5, t5};
  endfunction

  task automatic m_reset();
    m_ph = P_MG; m_len = 0; m_dur = 20; tsec = 0; m_rq = 2'b00; m_srv = 2'b00;
  endtask

  task automatic enter(input int ph, input int dur);
    m_ph = ph; m_dur = dur; m_len = 0;
  endtask

  task automatic model_edge();
    bit pk, clr;
    if (reset) begin m_reset(); return; end
    clr = 1'b0;
    if (ena) begin
      pk = is_peak(tsec);
      m_len++;
      case (m_ph)
        P_MG: if (m_len >= m_dur && m_rq != 2'b00) enter(P_MY, 3);
        P_MY: if (m_len >= m_dur) begin m_srv = m_rq; enter(P_SG, pk ? 10 : 15); end
        P_SG: if (m_len >= m_dur) enter(P_SY, 3);
        P_SY: if (m_len >= m_dur) begin
          clr = 1'b1;
          if (pk) enter(P_MG, 40); else enter(P_PED, 10);
        end
        default: if (m_len >= m_dur) enter(P_MG, pk ? 40 : 20);
      endcase
      tsec = (tsec + 1) % 86400;
    end
    m_rq = clr ? 2'b00 : (m_rq | {sensor2, sensor1});
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("lights", {20'd0, TL1, TL2, TL3, TL4, TL5, TL6}, {20'd0, exp_lights()});
    chk("time", {8'd0, hh, mm, ss}, {8'd0, exp_time()});
    chk("flags", {30'd0, peak, pm}, {30'd0, exp_flags()});
  endtask

  task automatic step(input bit do_chk);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (do_chk) chk_all();
  endtask

  task automatic run_until(input int ph, input int budget, input string tag);
    int n = 0;
    while (m_ph != ph && n < budget) begin step(1'b1); n++; end
    if (m_ph != ph) begin
      n_cmp++; n_err++;
      $error("FAIL %s: phase %0d not reached within %0d cycles, observed %0d", tag, ph, budget, m_ph);
    end
  endtask

  initial begin
    int first_y = 0, n_y = 0, n_sg = 0, n_sy = 0, n_ped = 0, n_tl4 = 0, nongreen = 0;
    logic [23:0] t_before;
    reset = 1'b1; ena = 1'b1; sensor1 = 1'b0; sensor2 = 1'b0;
    m_reset();
    step(1'b0);
    step(1'b0);
    chk("reset_lights", {20'd0, TL1, TL2, TL3, TL4, TL5, TL6}, 32'h0000_0A00);
    chk("reset_time", {8'd0, hh, mm, ss}, 32'd0);
    chk("reset_flags", {30'd0, peak, pm}, 32'd0);
    chk_all();
    reset = 1'b0;

    // off-peak demand on side road 1 at tick 5
    for (int e = 1; e <= 60; e++) begin
      sensor1 = (e == 5);
      step(1'b1);
      if (TL1 === Y && first_y == 0) first_y = e;
      if (TL1 === Y) n_y++;
      if (TL3 === G) n_sg++;
      if (TL3 === Y) n_sy++;
      if (TL5 === G && TL6 === G) n_ped++;
      if (TL4 !== 2'b00) n_tl4++;
    end
    chk("main_green_len", first_y, 20);
    chk("main_yel_len", n_y, 3);
    chk("side1_green_len", n_sg, 15);
    chk("side1_yel_len", n_sy, 3);
    chk("ped_len", n_ped, 10);
    chk("tl4_idle", n_tl4, 0);
    chk("back_main_green", {30'd0, TL1}, {30'd0, G});

    // random sensors and enable gaps
    for (int i = 0; i < 800; i++) begin
      ena = ($urandom_range(0, 7) != 0);
      sensor1 = ($urandom_range(0, 19) == 0);
      sensor2 = ($urandom_range(0, 19) == 0);
      step(1'b1);
    end
    ena = 1'b1; sensor2 = 1'b0;

    // freeze mid-SIDE_G
    sensor1 = 1'b1;
    run_until(P_SG, 300, "reach_side_g");
    sensor1 = 1'b0;
    step(1'b1); step(1'b1); step(1'b1);
    t_before = exp_time();
    ena = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sensor2 = (i == 20);
      step(1'b1);
    end
    chk("freeze_time", {8'd0, hh, mm, ss}, {8'd0, t_before});
    chk("freeze_side1_green", {30'd0, TL3}, {30'd0, G});
    ena = 1'b1; sensor2 = 1'b0;

    // asynchronous reset mid-PED
    run_until(P_PED, 300, "reach_ped");
    step(1'b1); step(1'b1);
    reset = 1'b1;
    #1;
    m_reset();
    chk("async_reset_lights", {20'd0, TL1, TL2, TL3, TL4, TL5, TL6}, 32'h0000_0A00);
    chk("async_reset_time", {8'd0, hh, mm, ss}, 32'd0);
    step(1'b1);
    reset = 1'b0;

    // one full day; random demand around the morning peak boundaries
    for (int t = 1; t <= 86400; t++) begin
      bit win = ((t >= 25100) && (t < 26500)) || ((t >= 35900) && (t < 36100));
      sensor1 = win && ($urandom_range(0, 9) == 0);
      sensor2 = win && ($urandom_range(0, 9) == 0);
      step(win || (t % 1000 == 0));
      if (t <= 1000 && TL1 !== G) nongreen++;
      if (t == 1000) chk("no_demand_main_green", nongreen, 0);
      case (t)
        60:    chk("min_rollover", {16'd0, mm, ss}, 32'h0000_0100);
        25200: chk("peak_start", {23'd0, hh, peak}, {23'd0, 8'h07, 1'b1});
        36000: chk("peak_end", {31'd0, peak}, 32'd0);
        43200: chk("pm_start", {23'd0, hh, pm}, {23'd0, 8'h12, 1'b1});
        86399: chk("day_last", {8'd0, hh, mm, ss}, 32'h0023_5959);
        86400: chk("day_wrap", {7'd0, hh, mm, ss, pm}, 32'd0);
        default: ;
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tlc_top.md
# tlc_top

Top-level traffic-light controller for a main road crossing two side roads, with a pedestrian phase. It contains a 24-hour time-of-day clock that drives the peak-hour and pm flags, and a Moore phase FSM that sequences six 2-bit light outputs. Timing adapts to peak hours, and side roads are served only on sensor demand.

## Interface
- CLKS_PER_SEC, 1: clk cycles per one-second tick.
- T_MAIN_PEAK, 40: main-green minimum during peak, in seconds.
- T_MAIN_OFF, 20: main-green minimum off-peak.
- T_SIDE_PEAK, 10: side-green duration during peak.
- T_SIDE_OFF, 15: side-green duration off-peak.
- T_YEL, 3: every yellow phase.
- T_PED, 10: pedestrian walk duration, off-peak only.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ena  in  1  tick enable; when low, the clock and FSM freeze.
- sensor1  in  1  vehicle present, side road 1.
- sensor2  in  1  vehicle present, side road 2.
- TL1, TL2  out  2 each  main road, both directions.
- TL3  out  2  side road 1.
- TL4  out  2  side road 2.
- TL5, TL6  out  2 each  pedestrian crossings.
- peak  out  1  time is inside a peak window.
- pm  out  1  hh is 12 or greater.
- hh, mm, ss  out  8 each  packed BCD time of day.

## Operation
- Light encoding: 00 = red, 01 = yellow, 10 = green, 11 = unused and never driven.
- Tick: a prescaler counts clk cycles while ena=1 and emits a tick every CLKS_PER_SEC cycles. When ena=0, the prescaler, time and FSM all hold.
- Time of day:
  - ss and mm run 00–59 and hh runs 00–23, all BCD.
  - Carries ripple within the same tick.
  - 23:59:59 wraps to 00:00:00.
- pm = (hh ≥ 0x12).
- peak = 1 when hh is in 07–09 or 17–19 (07:00:00–09:59:59 and 17:00:00–19:59:59).
- Request latches req1 and req2:
  - A latch sets on any clk cycle where its sensor is 1.
  - Both latches clear on the tick that leaves SIDE_Y.
  - A sensor that is still high sets its latch again on the next cycle.
- FSM states and outputs (lights not listed are red):
  - MAIN_G: TL1 and TL2 green.
  - MAIN_Y: TL1 and TL2 yellow.
  - SIDE_G: TL3 green if req1, TL4 green if req2.
  - SIDE_Y: the greens from SIDE_G become yellow.
  - PED: TL5 and TL6 green.
- Phase timer: loaded on phase entry using the peak value at that moment. It decrements on each tick. A phase of duration D lasts exactly D ticks.
- Transitions:
  - MAIN_G: when the minimum has expired and (req1 | req2), go to MAIN_Y. If no request, stay green and re-check each tick.
  - MAIN_Y to SIDE_G after T_YEL.
  - SIDE_G to SIDE_Y after the side duration. The set of served roads is frozen at SIDE_G entry.
  - SIDE_Y goes to PED if off-peak, or to MAIN_G if peak.
  - PED to MAIN_G after T_PED.
- A conflicting green (main together with side or ped) is impossible by construction.

## Timing
- Reset values:
  - hh = mm = ss = 0x00, pm = 0, peak = 0.
  - State MAIN_G with the timer loaded to T_MAIN_OFF; req latches clear; prescaler 0.
  - TL1 = TL2 = 10; TL3 through TL6 = 00.
- Time, state and timer update on the tick edge. Lights, peak and pm are decoded combinationally from registers, so they change in the same cycle.
- Reset asserted mid-phase forces the reset values immediately.
- A request arriving during MAIN_Y, SIDE_G, SIDE_Y or PED is held for the next cycle.
- A request arriving after the main minimum has expired causes the transition on the next tick.

## Structure
- Shared package tlc_pkg holds: the light encoding constants, the phase state enum, and the peak-window hour constants.
- Sub-module tlc_clock: the prescaler and BCD hh:mm:ss counter. Outputs are tick, hh, mm, ss, pm and peak.
- The top level holds the request latches, phase FSM, timer and light decode.

## Test plan
- Reset -> all time outputs 0x00, TL1 = TL2 = 10, TL3–TL6 = 00, peak = pm = 0.
- 60 ticks -> mm = 0x01, ss = 0x00. 43200 ticks -> hh = 0x12 and pm = 1. 86400 ticks -> 00:00:00 and pm = 0.
- 25200 ticks -> hh = 0x07 and peak = 1. 36000 ticks -> peak = 0.
- Off-peak, sensor1 pulsed at tick 5:
  - MAIN_G held 20 ticks, then TL1/TL2 = 01 for 3 ticks.
  - TL3 = 10 for 15 ticks, then 01 for 3 ticks; TL4 stays 00 throughout.
  - Then TL5/TL6 = 10 for 10 ticks, then MAIN_G.
- No sensors for 1000 ticks -> TL1/TL2 remain 10 throughout.
- ena = 0 for 50 cycles mid-SIDE_G -> time, state and lights are frozen. Reset asserted mid-PED -> MAIN_G immediately.
